// File: rtl/act_pwl_pipe_if.sv
// Streaming bus for act_pwl_pipe: input beat handshake plus output beat handshake.
// master drives beats in and accepts results; slave is the activation pipe.
interface act_pwl_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 4
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_mode;
    logic [LANES*DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );

endinterface

// File: rtl/act_pwl_pipe.sv
// act_pwl_pipe: 3-stage per-lane piecewise-linear tanh (and optional sigmoid).
// Optional sigmoid mode is enabled by defining ACT_PWL_SIGMOID_EN; without it
// in_mode is ignored and out_mode is tied low.
// Stage 1: |x| (saturated), sign, mode, sigmoid pre-shift.
// Stage 2: segment index, delta from segment breakpoint, slope shift.
// Stage 3: y = sign * (base + delta >> shift), optional sigmoid post-add.
module act_pwl_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    act_pwl_pipe_if.slave bus
);

    localparam int unsigned SEG_W = 3;
    localparam int unsigned SH_W  = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [SH_W-1:0]   sh_t;

    localparam word_t MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam word_t MAX_POS  = ~MOST_NEG;

    localparam word_t BP1 = word_t'(32'h008D);
    localparam word_t BP2 = word_t'(32'h0113);
    localparam word_t BP3 = word_t'(32'h017B);
    localparam word_t BP4 = word_t'(32'h01DA);
    localparam word_t BP5 = word_t'(32'h026B);

    localparam word_t BASE1    = word_t'(32'h008D);
    localparam word_t BASE2    = word_t'(32'h00D0);
    localparam word_t BASE3    = word_t'(32'h00EA);
    localparam word_t BASE4    = word_t'(32'h00F5);
    localparam word_t BASE_SAT = word_t'(32'h0100);

`ifdef ACT_PWL_SIGMOID_EN
    localparam word_t HALF = word_t'(32'h0080);
`endif

    // Stage valid flags and advance conditions
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;
    logic s3_v_q, s3_v_d;
    logic s1_adv_c, s2_adv_c, s3_adv_c;

    // Stage 1 payload
    word_t            abs_q [LANES];
    word_t            abs_d [LANES];
    logic [LANES-1:0] s1_neg_q, s1_neg_d;

    // Stage 2 payload
    seg_t             seg_q   [LANES];
    seg_t             seg_d   [LANES];
    word_t            delta_q [LANES];
    word_t            delta_d [LANES];
    sh_t              sh_q    [LANES];
    sh_t              sh_d    [LANES];
    logic [LANES-1:0] s2_neg_q, s2_neg_d;

    // Stage 3 payload
    word_t            y_q [LANES];
    word_t            y_d [LANES];

`ifdef ACT_PWL_SIGMOID_EN
    logic s1_mode_q, s1_mode_d;
    logic s2_mode_q, s2_mode_d;
    logic s3_mode_q, s3_mode_d;
`endif

    // Elastic pipeline: a stage moves when it is empty or its successor moves
    assign s3_adv_c     = !s3_v_q || bus.out_ready;
    assign s2_adv_c     = !s2_v_q || s3_adv_c;
    assign s1_adv_c     = !s1_v_q || s2_adv_c;
    assign bus.in_ready = s1_adv_c;

    // Stage 1: optional sigmoid pre-shift, then sign and saturated magnitude
    always_comb begin
        word_t x_c;
        word_t xs_c;
        x_c      = '0;
        xs_c     = '0;
        s1_v_d   = s1_v_q;
        s1_neg_d = s1_neg_q;
        for (int i = 0; i < int'(LANES); i++) begin
            abs_d[i] = abs_q[i];
        end
`ifdef ACT_PWL_SIGMOID_EN
        s1_mode_d = s1_mode_q;
`endif
        if (s1_adv_c) begin
            s1_v_d = bus.in_valid;
`ifdef ACT_PWL_SIGMOID_EN
            s1_mode_d = bus.in_mode;
`endif
            for (int i = 0; i < int'(LANES); i++) begin
                x_c = bus.in_data[i*DATA_W +: DATA_W];
`ifdef ACT_PWL_SIGMOID_EN
                xs_c = bus.in_mode ? word_t'($signed(x_c) >>> 1) : x_c;
`else
                xs_c = x_c;
`endif
                s1_neg_d[i] = xs_c[DATA_W-1];
                if (xs_c == MOST_NEG) begin
                    abs_d[i] = MAX_POS;
                end else if (xs_c[DATA_W-1]) begin
                    abs_d[i] = word_t'(~xs_c + word_t'(1));
                end else begin
                    abs_d[i] = xs_c;
                end
            end
        end
    end

    // Stage 2: locate segment, offset from its breakpoint, and slope shift
    always_comb begin
        word_t a_c;
        a_c      = '0;
        s2_v_d   = s2_v_q;
        s2_neg_d = s2_neg_q;
        for (int i = 0; i < int'(LANES); i++) begin
            seg_d[i]   = seg_q[i];
            delta_d[i] = delta_q[i];
            sh_d[i]    = sh_q[i];
        end
`ifdef ACT_PWL_SIGMOID_EN
        s2_mode_d = s2_mode_q;
`endif
        if (s2_adv_c) begin
            s2_v_d   = s1_v_q;
            s2_neg_d = s1_neg_q;
`ifdef ACT_PWL_SIGMOID_EN
            s2_mode_d = s1_mode_q;
`endif
            for (int i = 0; i < int'(LANES); i++) begin
                a_c = abs_q[i];
                if (a_c < BP1) begin
                    seg_d[i]   = seg_t'(0);
                    delta_d[i] = a_c;
                    sh_d[i]    = sh_t'(0);
                end else if (a_c < BP2) begin
                    seg_d[i]   = seg_t'(1);
                    delta_d[i] = a_c - BP1;
                    sh_d[i]    = sh_t'(1);
                end else if (a_c < BP3) begin
                    seg_d[i]   = seg_t'(2);
                    delta_d[i] = a_c - BP2;
                    sh_d[i]    = sh_t'(2);
                end else if (a_c < BP4) begin
                    seg_d[i]   = seg_t'(3);
                    delta_d[i] = a_c - BP3;
                    sh_d[i]    = sh_t'(3);
                end else if (a_c < BP5) begin
                    seg_d[i]   = seg_t'(4);
                    delta_d[i] = a_c - BP4;
                    sh_d[i]    = sh_t'(4);
                end else begin
                    seg_d[i]   = seg_t'(5);
                    delta_d[i] = '0;
                    sh_d[i]    = sh_t'(0);
                end
            end
        end
    end

    // Stage 3: segment base plus scaled delta, restore sign, optional sigmoid add
    always_comb begin
        word_t base_c;
        word_t mag_c;
        word_t yt_c;
        base_c = '0;
        mag_c  = '0;
        yt_c   = '0;
        s3_v_d = s3_v_q;
        for (int i = 0; i < int'(LANES); i++) begin
            y_d[i] = y_q[i];
        end
`ifdef ACT_PWL_SIGMOID_EN
        s3_mode_d = s3_mode_q;
`endif
        if (s3_adv_c) begin
            s3_v_d = s2_v_q;
`ifdef ACT_PWL_SIGMOID_EN
            s3_mode_d = s2_mode_q;
`endif
            for (int i = 0; i < int'(LANES); i++) begin
                case (seg_q[i])
                    seg_t'(0): base_c = '0;
                    seg_t'(1): base_c = BASE1;
                    seg_t'(2): base_c = BASE2;
                    seg_t'(3): base_c = BASE3;
                    seg_t'(4): base_c = BASE4;
                    default:   base_c = BASE_SAT;
                endcase
                mag_c = base_c + (delta_q[i] >> sh_q[i]);
                yt_c  = s2_neg_q[i] ? word_t'(~mag_c + word_t'(1)) : mag_c;
`ifdef ACT_PWL_SIGMOID_EN
                y_d[i] = s2_mode_q ? word_t'(HALF + word_t'($signed(yt_c) >>> 1)) : yt_c;
`else
                y_d[i] = yt_c;
`endif
            end
        end
    end

    // Pipeline registers; reset empties every stage and clears the output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s3_v_q   <= 1'b0;
            s1_neg_q <= '0;
            s2_neg_q <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                abs_q[i]   <= '0;
                seg_q[i]   <= '0;
                delta_q[i] <= '0;
                sh_q[i]    <= '0;
                y_q[i]     <= '0;
            end
`ifdef ACT_PWL_SIGMOID_EN
            s1_mode_q <= 1'b0;
            s2_mode_q <= 1'b0;
            s3_mode_q <= 1'b0;
`endif
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            s3_v_q   <= s3_v_d;
            s1_neg_q <= s1_neg_d;
            s2_neg_q <= s2_neg_d;
            for (int i = 0; i < int'(LANES); i++) begin
                abs_q[i]   <= abs_d[i];
                seg_q[i]   <= seg_d[i];
                delta_q[i] <= delta_d[i];
                sh_q[i]    <= sh_d[i];
                y_q[i]     <= y_d[i];
            end
`ifdef ACT_PWL_SIGMOID_EN
            s1_mode_q <= s1_mode_d;
            s2_mode_q <= s2_mode_d;
            s3_mode_q <= s3_mode_d;
`endif
        end
    end

    // Output beat packing
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            bus.out_data[i*DATA_W +: DATA_W] = y_q[i];
        end
    end

    assign bus.out_valid = s3_v_q;
`ifdef ACT_PWL_SIGMOID_EN
    assign bus.out_mode  = s3_mode_q;
`else
    assign bus.out_mode  = 1'b0;
`endif

endmodule

// File: tb/tb_act_pwl_pipe.sv
// Bench for act_pwl_pipe: fixed vectors with latency checks, a randomized
// stalled stream against a reference model, and a mid-stream reset sequence.
module tb_act_pwl_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned BUS_W  = DATA_W * LANES;
    localparam int          N_BEATS = 40;

`ifdef ACT_PWL_SIGMOID_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    act_pwl_pipe_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    act_pwl_pipe #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the piecewise rules written as integer arithmetic
    function automatic int f_ref(input int a);
        if (a < 'h8D)  return a;
        if (a < 'h113) return 'h8D + ((a - 'h8D) >> 1);
        if (a < 'h17B) return 'hD0 + ((a - 'h113) >> 2);
        if (a < 'h1DA) return 'hEA + ((a - 'h17B) >> 3);
        if (a < 'h26B) return 'hF5 + ((a - 'h1DA) >> 4);
        return 'h100;
    endfunction

    function automatic int tanh_ref(input int x);
        int a;
        if (x < 0) begin
            a = -x;
            if (a > 32767) a = 32767;
            return -f_ref(a);
        end
        return f_ref(x);
    endfunction

    function automatic logic [15:0] act_ref(input logic [15:0] x, input logic mode);
        int xi;
        int t;
        int y;
        xi = int'($signed(x));
        if (SIG_EN && mode) begin
            t = tanh_ref(xi >>> 1);
            y = 128 + (t >>> 1);
        end else begin
            y = tanh_ref(xi);
        end
        return 16'(y);
    endfunction

    function automatic logic [BUS_W-1:0] beat_ref(input logic [BUS_W-1:0] d, input logic mode);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            r[i*DATA_W +: DATA_W] = act_ref(d[i*DATA_W +: DATA_W], mode);
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_x();
        logic [15:0] sp [4];
        sp[0] = 16'h8000; sp[1] = 16'h7FFF; sp[2] = 16'h0000; sp[3] = 16'hFFFF;
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return sp[$urandom_range(0, 3)];
            default: return 16'($urandom_range(0, 'h600) - 'h300);
        endcase
    endfunction

    typedef struct {
        string            name;
        logic             mode;
        logic [BUS_W-1:0] data;
        logic [BUS_W-1:0] exp_data;
        logic             exp_mode;
    } vec_t;

    typedef struct {
        logic [BUS_W-1:0] data;
        logic             mode;
    } beat_t;

    vec_t vecs[$];

    // One isolated beat: accept, confirm nothing after 2 edges, result after 3rd
    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = v.mode;
        bus.in_data   = v.data;
        check({v.name, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check({v.name, "_early_valid"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        check({v.name, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({v.name, "_data"}, 64'(bus.out_data), 64'(v.exp_data));
        check({v.name, "_mode"}, 64'(bus.out_mode), 64'(v.exp_mode));
    endtask

    // Randomized stream with random downstream stalls, scoreboarded in order
    task automatic run_stream();
        beat_t            exp_q[$];
        beat_t            e;
        logic             pending;
        logic [BUS_W-1:0] cur_data;
        logic             cur_mode;
        int               sent;
        int               got;
        logic             hold;
        logic [BUS_W-1:0] hold_data;
        logic             hold_mode;
        pending = 1'b0; sent = 0; got = 0; hold = 1'b0;
        cur_data = '0; cur_mode = 1'b0; hold_data = '0; hold_mode = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < N_BEATS; cyc++) begin
            @(posedge clk); #1;
            if (!pending && sent < N_BEATS) begin
                if (sent < 20 || $urandom_range(0, 3) != 0) begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        cur_data[i*DATA_W +: DATA_W] = rand_x();
                    end
                    cur_mode = 1'($urandom_range(0, 1));
                    pending  = 1'b1;
                end
            end
            bus.in_valid  = pending;
            bus.in_data   = cur_data;
            bus.in_mode   = cur_mode;
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold) begin
                check("stall_valid", 64'(bus.out_valid), 64'(1));
                check("stall_data", 64'(bus.out_data), 64'(hold_data));
                check("stall_mode", 64'(bus.out_mode), 64'(hold_mode));
                hold = 1'b0;
            end
            if (pending && bus.in_ready) begin
                e.data = beat_ref(cur_data, cur_mode);
                e.mode = SIG_EN ? cur_mode : 1'b0;
                exp_q.push_back(e);
                pending = 1'b0;
                sent++;
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_data", 64'(bus.out_data), 64'(e.data));
                        check("stream_mode", 64'(bus.out_mode), 64'(e.mode));
                        got++;
                    end
                end else begin
                    hold      = 1'b1;
                    hold_data = bus.out_data;
                    hold_mode = bus.out_mode;
                end
            end
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_count", 64'(got), 64'(N_BEATS));
    endtask

    // Fill all three stages under stall, reset, then check only fresh beats emerge
    task automatic run_reset_midstream();
        int               outs;
        logic [BUS_W-1:0] first;
        outs = 0; first = '0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = {4{16'h0300 + 16'(k)}};
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("fill_out_valid", 64'(bus.out_valid), 64'(1));
        check("fill_in_ready", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_out_data", 64'(bus.out_data), 64'(0));
        check("midrst_out_mode", 64'(bus.out_mode), 64'(0));
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", 64'(bus.in_ready), 64'(1));
        check("postrst_out_valid", 64'(bus.out_valid), 64'(0));
        bus.in_data   = {4{16'h0100}};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (outs == 0) first = bus.out_data;
                outs++;
            end
        end
        check("postrst_beat_count", 64'(outs), 64'(1));
        check("postrst_first_beat", 64'(first), 64'({4{16'h00C6}}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{name: "tanh_basic", mode: 1'b0,
                         data: {16'h0300, 16'hFF00, 16'h0100, 16'h0000},
                         exp_data: {16'h0100, 16'hFF3A, 16'h00C6, 16'h0000}, exp_mode: 1'b0});
        vecs.push_back('{name: "tanh_extreme", mode: 1'b0,
                         data: {16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000},
                         exp_data: {16'hFFFF, 16'h0001, 16'h0100, 16'hFF00}, exp_mode: 1'b0});
        vecs.push_back('{name: "seg_bp01", mode: 1'b0,
                         data: {16'h0113, 16'h0112, 16'h008D, 16'h008C},
                         exp_data: {16'h00D0, 16'h00CF, 16'h008D, 16'h008C}, exp_mode: 1'b0});
        vecs.push_back('{name: "seg_bp23", mode: 1'b0,
                         data: {16'h01DA, 16'h01D9, 16'h017B, 16'h017A},
                         exp_data: {16'h00F5, 16'h00F5, 16'h00EA, 16'h00E9}, exp_mode: 1'b0});
        vecs.push_back('{name: "seg_bp4_neg", mode: 1'b0,
                         data: {16'hFE26, 16'hFD95, 16'h026B, 16'h026A},
                         exp_data: {16'hFF0B, 16'hFF00, 16'h0100, 16'h00FE}, exp_mode: 1'b0});
`ifdef ACT_PWL_SIGMOID_EN
        vecs.push_back('{name: "sigmoid_basic", mode: 1'b1,
                         data: {16'h7FFF, 16'hF000, 16'h0200, 16'h0000},
                         exp_data: {16'h0100, 16'h0000, 16'h00E3, 16'h0080}, exp_mode: 1'b1});
        vecs.push_back('{name: "sigmoid_neg", mode: 1'b1,
                         data: {16'hFE00, 16'h0100, 16'hFFFE, 16'h8000},
                         exp_data: {16'h001D, 16'h00C0, 16'h007F, 16'h0000}, exp_mode: 1'b1});
`else
        vecs.push_back('{name: "tanh_only_mode1", mode: 1'b1,
                         data: {4{16'h0100}},
                         exp_data: {4{16'h00C6}}, exp_mode: 1'b0});
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_mode", 64'(bus.out_mode), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 64'(bus.in_ready), 64'(1));

        foreach (vecs[k]) run_vec(vecs[k]);

        run_stream();
        run_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/act_pwl_pipe.md
ACT_PWL_PIPE -- requirements
Module: act_pwl_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed sample width, format Q(DATA_W-8).8, legal range 12..32.
REQ-002 SHALL have parameter LANES, default 4, meaning parallel samples per beat, legal range 1..16.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset; `clk  in  1  rising-edge clock`.
REQ-004 SHALL provide `rst_n  in  1  async active-low reset`.
REQ-005 SHALL provide `in_valid  in  1  input beat valid`.
REQ-006 SHALL provide `in_ready  out  1  input beat accepted when in_valid&in_ready`.
REQ-007 SHALL provide `in_mode  in  1  0=tanh, 1=sigmoid, per beat`.
REQ-008 SHALL provide `in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]`.
REQ-009 SHALL provide `out_valid  out  1  output beat valid`.
REQ-010 SHALL provide `out_ready  in  1  downstream accepts when out_valid&out_ready`.
REQ-011 SHALL provide `out_mode  out  1  in_mode carried with the beat`.
REQ-012 SHALL provide `out_data  out  LANES*DATA_W  activation results, same lane packing, Q.8`.

Function
REQ-013 SHALL compute tanh per lane with odd symmetry: y = sign(x)*f(|x|), where |x| of the most negative input is treated as the largest positive value.
REQ-014 SHALL define f(a) in Q.8 as follows: a<0x8D gives a; a<0x113 gives 0x8D+((a-0x8D)>>1); a<0x17B gives 0xD0+((a-0x113)>>2); a<0x1DA gives 0xEA+((a-0x17B)>>3); a<0x26B gives 0xF5+((a-0x1DA)>>4); otherwise 0x100.
REQ-015 SHALL treat breakpoints as unsigned constants zero-extended to DATA_W, and all shifts within f SHALL be logical on non-negative values.
REQ-016 SHALL compute sigmoid, when in_mode=1, as t = tanh(x>>>1) (arithmetic shift), then y = 0x80 + (t>>>1), with result range 0x0000..0x0100.
REQ-017 SHALL sign-extend results to DATA_W; no output SHALL exceed magnitude 0x100.
REQ-018 SHALL be a 3-stage pipeline: S1 registers |x|, sign, mode and sigmoid pre-shift; S2 registers segment index, delta and shift; S3 registers y.
REQ-019 SHALL have a latency of exactly 3 cycles from input acceptance to out_valid when out_ready is held at 1, with a throughput of one beat per cycle.
REQ-020 SHALL advance each stage when that stage is empty or the next stage advances, giving in_ready = !S1_valid | S1_advance.
REQ-021 SHALL hold out_data and out_mode stable while out_valid=1 and out_ready=0; no beat SHALL be dropped or duplicated.
REQ-022 SHALL deliver beats in order, and lanes SHALL be independent with no cross-lane dependence.
REQ-023 SHALL not combinationally depend in_ready on in_valid.

Reset
REQ-024 SHALL, on assertion of rst_n=0, asynchronously clear all stage valid flags, so out_valid=0, out_data=0 and out_mode=0.
REQ-025 SHALL drive in_ready=1 in the cycle after reset deassertion.
REQ-026 SHALL discard beats in flight when reset is asserted mid-stream; the first output after reset SHALL come from the first beat accepted after reset.

Configuration
REQ-027 SHALL, with macro ACT_PWL_SIGMOID_EN defined, implement sigmoid mode per REQ-016.
REQ-028 SHALL, without ACT_PWL_SIGMOID_EN defined, ignore in_mode, compute tanh only, tie out_mode to 0, and include no sigmoid pre-shift or post-add logic.

Verification
REQ-029 SHALL cover: tanh with lanes x=0x0000, 0x0100, 0xFF00, 0x0300 -> y=0x0000, 0x00C6, 0xFF3A, 0x0100, 3 cycles after acceptance.
REQ-030 SHALL cover: tanh with x=0x8000 and 0x7FFF -> y=0xFF00 and 0x0100 (no abs overflow).
REQ-031 SHALL cover: sigmoid (macro defined) with x=0x0000, 0x0200, 0xF000 -> y=0x0080, 0x00E3, 0x0000.
REQ-032 SHALL cover: 20 back-to-back beats with out_ready toggling pseudo-randomly -> all 20 results in order, each matching the reference model, and out_data stable during stalls.
REQ-033 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale beats emitted afterwards, and in_ready=1 the next cycle.
REQ-034 SHALL cover: macro undefined with in_mode=1 and x=0x0100 -> y=0x00C6 and out_mode=0.
